// File: rtl/clock_set_arbiter.sv
// Round-robin button/UART arbiter producing one-cycle sec/min/hour increment strobes.
// Defining CLOCK_ARB_REPEAT_EN adds auto-repeat while a button is held.
module clock_set_arbiter #(
    parameter int GAP_CYC    = 2,
    parameter int REPEAT_CYC = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_sec,
    input  logic       i_btn_min,
    input  logic       i_btn_hour,
    input  logic       i_uart_valid,
    input  logic [1:0] i_uart_sel,
    output logic       o_uart_ready,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic       o_src,
    output logic       o_busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] btn_prev_q, btn_prev_d;
    logic [2:0] btn_pend_q, btn_pend_d;
    logic       uart_pend_q, uart_pend_d;
    logic [1:0] uart_sel_q, uart_sel_d;
    logic       last_src_q, last_src_d;
    logic       grant_src_q, grant_src_d;
    logic [2:0] grant_tgt_q, grant_tgt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [2:0] inc_q, inc_d;
    logic       src_q, src_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;

    logic [2:0] btn_in;
    logic [2:0] btn_rise;
    logic [2:0] btn_rep;
    logic       any_req;
    logic       pick_uart;
    logic [2:0] pick_tgt;
    logic       uart_acc;

    assign btn_in   = {i_btn_hour, i_btn_min, i_btn_sec};
    assign btn_rise = btn_in & ~btn_prev_q;
    assign uart_acc = i_uart_valid & ready_q;

`ifdef CLOCK_ARB_REPEAT_EN
    localparam int HW = $clog2(REPEAT_CYC + 1);

    logic [HW-1:0] hold_q [3];
    logic [HW-1:0] hold_d [3];

    // Counter restarts on each press and wraps every REPEAT_CYC held cycles.
    always_comb begin
        btn_rep = '0;
        for (int i = 0; i < 3; i++) begin
            hold_d[i] = '0;
            if (btn_in[i] && !btn_rise[i]) begin
                if (hold_q[i] == HW'(REPEAT_CYC - 1)) begin
                    btn_rep[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                hold_q[i] <= '0;
            end else begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYC;
    assign btn_rep       = '0;
`endif

    // Alternate on a tie; buttons are fixed priority sec > min > hour.
    always_comb begin
        any_req   = (|btn_pend_q) | uart_pend_q;
        pick_uart = uart_pend_q & (~(|btn_pend_q) | ~last_src_q);
        pick_tgt  = 3'b000;
        if (pick_uart) begin
            unique case (uart_sel_q)
                2'd0:    pick_tgt = 3'b001;
                2'd1:    pick_tgt = 3'b010;
                2'd2:    pick_tgt = 3'b100;
                default: pick_tgt = 3'b000;
            endcase
        end else if (btn_pend_q[0]) begin
            pick_tgt = 3'b001;
        end else if (btn_pend_q[1]) begin
            pick_tgt = 3'b010;
        end else if (btn_pend_q[2]) begin
            pick_tgt = 3'b100;
        end
    end

    always_comb begin
        state_d     = state_q;
        btn_prev_d  = btn_in;
        btn_pend_d  = btn_pend_q;
        uart_pend_d = uart_pend_q;
        uart_sel_d  = uart_sel_q;
        last_src_d  = last_src_q;
        grant_src_d = grant_src_q;
        grant_tgt_d = grant_tgt_q;
        gap_cnt_d   = gap_cnt_q;
        inc_d       = 3'b000;
        src_d       = src_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ISSUE;
                    grant_src_d = pick_uart;
                    grant_tgt_d = pick_tgt;
                    inc_d       = pick_tgt;
                    src_d       = pick_uart;
                end
            end
            ISSUE: begin
                if (grant_src_q) begin
                    uart_pend_d = 1'b0;
                end else begin
                    btn_pend_d = btn_pend_q & ~grant_tgt_q;
                end
                last_src_d = grant_src_q;
                gap_cnt_d  = 8'(GAP_CYC - 1);
                state_d    = GAP;
            end
            GAP: begin
                // Issue straight out of the gap so strobes can be GAP_CYC+1 apart.
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else if (any_req) begin
                    state_d     = ISSUE;
                    grant_src_d = pick_uart;
                    grant_tgt_d = pick_tgt;
                    inc_d       = pick_tgt;
                    src_d       = pick_uart;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        btn_pend_d = btn_pend_d | btn_rise | btn_rep;

        if (uart_acc && (i_uart_sel != 2'd3)) begin
            uart_pend_d = 1'b1;
            uart_sel_d  = i_uart_sel;
        end

        ready_d = ~(uart_pend_q | uart_pend_d);
        busy_d  = (state_d != IDLE) | (|btn_pend_d) | uart_pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            btn_prev_q  <= 3'b111;
            btn_pend_q  <= 3'b000;
            uart_pend_q <= 1'b0;
            uart_sel_q  <= 2'd0;
            last_src_q  <= 1'b1;
            grant_src_q <= 1'b0;
            grant_tgt_q <= 3'b000;
            gap_cnt_q   <= 8'd0;
            inc_q       <= 3'b000;
            src_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_prev_d;
            btn_pend_q  <= btn_pend_d;
            uart_pend_q <= uart_pend_d;
            uart_sel_q  <= uart_sel_d;
            last_src_q  <= last_src_d;
            grant_src_q <= grant_src_d;
            grant_tgt_q <= grant_tgt_d;
            gap_cnt_q   <= gap_cnt_d;
            inc_q       <= inc_d;
            src_q       <= src_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign o_inc_sec    = inc_q[0];
    assign o_inc_min    = inc_q[1];
    assign o_inc_hour   = inc_q[2];
    assign o_src        = src_q;
    assign o_busy       = busy_q;
    assign o_uart_ready = ready_q;

endmodule

// File: tb/tb_clock_set_arbiter.sv
// Scoreboard bench for clock_set_arbiter: directed stimulus queues expected strobes,
// a negedge monitor pops and compares target, source and arrival cycle.
module tb_clock_set_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_btn_sec, i_btn_min, i_btn_hour;
    logic       i_uart_valid;
    logic [1:0] i_uart_sel;
    logic       o_uart_ready;
    logic       o_inc_sec, o_inc_min, o_inc_hour;
    logic       o_src, o_busy;

    typedef struct {
        logic [2:0] inc;
        logic       src;
        int         cyc;
    } exp_t;

    localparam logic [2:0] SEC  = 3'b001;
    localparam logic [2:0] MIN  = 3'b010;
    localparam logic [2:0] HOUR = 3'b100;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   last_s = -100;

    clock_set_arbiter #(
        .GAP_CYC   (2),
        .REPEAT_CYC(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_sec   (i_btn_sec),
        .i_btn_min   (i_btn_min),
        .i_btn_hour  (i_btn_hour),
        .i_uart_valid(i_uart_valid),
        .i_uart_sel  (i_uart_sel),
        .o_uart_ready(o_uart_ready),
        .o_inc_sec   (o_inc_sec),
        .o_inc_min   (o_inc_min),
        .o_inc_hour  (o_inc_hour),
        .o_src       (o_src),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] inc, input logic src, input int c);
        exp_t e;
        e.inc = inc;
        e.src = src;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d strobes still outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every strobe must match the head of the queue in target, source and cycle.
    initial begin
        logic [2:0] inc;
        exp_t       e;
        forever begin
            @(negedge clk);
            inc = {o_inc_hour, o_inc_min, o_inc_sec};
            if (|inc) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: got inc=%b src=%b at cycle %0d, expected none",
                             inc, o_src, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (inc !== e.inc || o_src !== e.src || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL strobe: got inc=%b src=%b cycle %0d, expected inc=%b src=%b cycle %0d",
                                 inc, o_src, cyc, e.inc, e.src, e.cyc);
                    end
                end
                n_vec++;
                if (cyc - last_s < 3) begin
                    n_bad++;
                    $display("FAIL strobe_gap: got spacing %0d, expected >= 3", cyc - last_s);
                end
                last_s = cyc;
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missed_strobe: got none by cycle %0d, expected inc=%b src=%b at cycle %0d",
                         cyc, e.inc, e.src, e.cyc);
            end
        end
    end

    initial begin
        int d;
        rst          = 1'b0;
        i_btn_sec    = 1'b0;
        i_btn_min    = 1'b1;
        i_btn_hour   = 1'b0;
        i_uart_valid = 1'b0;
        i_uart_sel   = 2'd0;

        // Reset with btn_min held high: no strobe afterwards.
        tick(3);
        chk("rst_inc", {5'd0, o_inc_hour, o_inc_min, o_inc_sec}, 8'd0);
        chk("rst_src", {7'd0, o_src}, 8'd0);
        chk("rst_busy", {7'd0, o_busy}, 8'd0);
        chk("rst_ready", {7'd0, o_uart_ready}, 8'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_ready", {7'd0, o_uart_ready}, 8'd1);
        chk("post_rst_busy", {7'd0, o_busy}, 8'd0);
        tick(6);
        i_btn_min = 1'b0;
        tick(3);
        chk_drained("held_btn_no_strobe");

        // Tie: button wins first because last_src resets to UART.
        d = cyc;
        i_btn_hour   = 1'b1;
        i_uart_valid = 1'b1;
        i_uart_sel   = 2'd1;
        push(HOUR, 1'b0, d + 2);
        push(MIN, 1'b1, d + 5);
        tick();
        chk("tie_ready_drop", {7'd0, o_uart_ready}, 8'd0);
        i_uart_valid = 1'b0;
        i_uart_sel   = 2'd0;
        tick(3);
        i_btn_hour = 1'b0;
        tick(6);
        chk_drained("tie");

        // Single button edge latency.
        d = cyc;
        i_btn_sec = 1'b1;
        push(SEC, 1'b0, d + 2);
        tick();
        chk("lat_busy", {7'd0, o_busy}, 8'd1);
        tick(2);
        i_btn_sec = 1'b0;
        tick(6);
        chk_drained("latency");

        // UART valid held 4 cycles: one accept, one strobe.
        chk("uart_ready_idle", {7'd0, o_uart_ready}, 8'd1);
        d = cyc;
        i_uart_valid = 1'b1;
        i_uart_sel   = 2'd2;
        push(HOUR, 1'b1, d + 2);
        tick();
        chk("uart_ready_after_acc", {7'd0, o_uart_ready}, 8'd0);
        tick(3);
        i_uart_valid = 1'b0;
        i_uart_sel   = 2'd0;
        tick(8);
        chk("uart_ready_back", {7'd0, o_uart_ready}, 8'd1);
        chk_drained("uart_hold");

        // Reserved target is consumed silently.
        i_uart_valid = 1'b1;
        i_uart_sel   = 2'd3;
        tick();
        i_uart_valid = 1'b0;
        i_uart_sel   = 2'd0;
        chk("sel3_busy", {7'd0, o_busy}, 8'd0);
        chk("sel3_ready", {7'd0, o_uart_ready}, 8'd1);
        tick(4);
        chk("sel3_busy_later", {7'd0, o_busy}, 8'd0);
        chk_drained("sel3");

        // Re-press on the clear edge and again during the gap: one extra strobe.
        d = cyc;
        push(SEC, 1'b0, d + 2);
        push(SEC, 1'b0, d + 5);
        i_btn_sec = 1'b1;
        tick();
        i_btn_sec = 1'b0;
        tick();
        i_btn_sec = 1'b1;
        tick();
        i_btn_sec = 1'b0;
        tick();
        i_btn_sec = 1'b1;
        tick();
        i_btn_sec = 1'b0;
        tick(8);
        chk_drained("merge_gap");

        // Reset during GAP drops the pending button request.
        d = cyc;
        i_btn_sec    = 1'b1;
        i_uart_valid = 1'b1;
        i_uart_sel   = 2'd1;
        push(MIN, 1'b1, d + 2);
        tick();
        i_uart_valid = 1'b0;
        i_uart_sel   = 2'd0;
        tick(2);
        rst = 1'b0;
        tick();
        chk("midrst_inc", {5'd0, o_inc_hour, o_inc_min, o_inc_sec}, 8'd0);
        chk("midrst_src", {7'd0, o_src}, 8'd0);
        chk("midrst_busy", {7'd0, o_busy}, 8'd0);
        chk("midrst_ready", {7'd0, o_uart_ready}, 8'd0);
        rst = 1'b1;
        tick();
        chk("midrst_ready_back", {7'd0, o_uart_ready}, 8'd1);
        chk("midrst_busy_after", {7'd0, o_busy}, 8'd0);
        tick(8);
        i_btn_sec = 1'b0;
        tick(4);
        chk_drained("mid_reset");

        // Held button for 30 cycles.
        d = cyc;
        i_btn_min = 1'b1;
        push(MIN, 1'b0, d + 2);
`ifdef CLOCK_ARB_REPEAT_EN
        push(MIN, 1'b0, d + 10);
        push(MIN, 1'b0, d + 18);
        push(MIN, 1'b0, d + 26);
`endif
        tick(30);
        i_btn_min = 1'b0;
        tick(8);
        chk_drained("hold_repeat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
